// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder, DIGIT bits per clock, LSB first
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    // Keep the counter at least one bit wide so STEPS == 1 still elaborates.
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic load;
    logic step;
    logic last;

    logic [DIGIT-1:0]       slice_sum;
    logic [DIGIT:0]         chain;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_shift;

    // Busy is simply "an operation is in flight".
    assign busy = (state == RUN);

    // Next-state and step control: accept start only in IDLE, leave RUN on the last step.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One DIGIT-bit ripple slice; chain[i] is the carry into bit i of the slice.
    always_comb begin
        chain[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            slice_sum[i] = a_sr[i] ^ b_sr[i] ^ chain[i];
            chain[i+1]   = (a_sr[i] & b_sr[i]) | (chain[i] & (a_sr[i] ^ b_sr[i]));
        end
        // New digit enters the sum register from the MSB end, old bits move down.
        sum_cat   = {slice_sum, sum_sr};
        sum_shift = WIDTH'(sum_cat >> DIGIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand shift registers, carry, step counter and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sr   <= a;
                b_sr   <= b;
                sum_sr <= '0;
                carry  <= cin;
                cnt    <= '0;
            end
            if (step) begin
                a_sr   <= a_sr >> DIGIT;
                b_sr   <= b_sr >> DIGIT;
                sum_sr <= sum_shift;
                carry  <= chain[DIGIT];
                cnt    <= cnt + 1'b1;
            end
            // On the final step the slice's top bit is the operand MSB, so
            // chain[DIGIT-1] is the carry into the MSB.
            if (last) begin
                sum  <= sum_shift;
                cout <= chain[DIGIT];
                ovf  <= chain[DIGIT] ^ chain[DIGIT-1];
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic       s81, c81, busy81, done81, cout81, ovf81;
    logic [7:0] a81, b81, sum81;
    logic       s84, c84, busy84, done84, cout84, ovf84;
    logic [7:0] a84, b84, sum84;
    logic       s42, c42, busy42, done42, cout42, ovf42;
    logic [3:0] a42, b42, sum42;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (
        .clk(clk), .rst(rst), .start(s81), .a(a81), .b(b81), .cin(c81),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .ovf(ovf81));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst(rst), .start(s84), .a(a84), .b(b84), .cin(c84),
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .ovf(ovf84));

    serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst(rst), .start(s42), .a(a42), .b(b42), .cin(c42),
        .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .ovf(ovf42));

    typedef struct {
        int         dut;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         lat;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic dn(input int w);
        return (w == 0) ? done81 : (w == 1) ? done84 : done42;
    endfunction

    // Reference: plain integer arithmetic on a w-bit word.
    task automatic ref_add(input int w, input int a, input int b, input int c,
                           output logic [7:0] s, output logic co, output logic ov);
        int u, sa, sb, ss;
        u  = a + b + c;
        s  = 8'(u & ((1 << w) - 1));
        co = ((u >> w) & 1) != 0;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        ss = sa + sb + c;
        ov = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    endtask

    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [7:0] s, output logic co, output logic ov, output int lat);
        case (w)
            0:       begin a81 = a; b81 = b; c81 = c; s81 = 1'b1; end
            1:       begin a84 = a; b84 = b; c84 = c; s84 = 1'b1; end
            default: begin a42 = a[3:0]; b42 = b[3:0]; c42 = c; s42 = 1'b1; end
        endcase
        tick;
        s81 = 1'b0; s84 = 1'b0; s42 = 1'b0;
        // Operands must have been captured at the start edge.
        a81 = ~a81; b81 = ~b81; a84 = ~a84; b84 = ~b84; a42 = ~a42; b42 = ~b42;
        lat = 0;
        while (!dn(w) && lat < 40) begin
            tick;
            lat++;
        end
        if (!dn(w)) check("done_seen", 32'(dn(w)), 32'd1);
        case (w)
            0:       begin s = sum81; co = cout81; ov = ovf81; end
            1:       begin s = sum84; co = cout84; ov = ovf84; end
            default: begin s = {4'h0, sum42}; co = cout42; ov = ovf42; end
        endcase
    endtask

    initial begin
        vec_t       vecs[$];
        logic [7:0] s, es;
        logic       co, ov, eco, eov;
        int         lat, n;
        logic       seen;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[$];
        logic [7:0] s, es, ra, rb;
        logic       co, ov, eco, eov, rc;
        int         lat, n;
        logic       seen;

        rst = 1'b1;
        s81 = 0; s84 = 0; s42 = 0;
        a81 = 0; b81 = 0; c81 = 0; a84 = 0; b84 = 0; c84 = 0; a42 = 0; b42 = 0; c42 = 0;
        repeat (3) tick;
        check("rst_busy", 32'(busy81), 0);
        check("rst_done", 32'(done81), 0);
        check("rst_sum", 32'(sum81), 0);
        check("rst_cout", 32'(cout81), 0);
        check("rst_ovf", 32'(ovf81), 0);
        check("rst_busy84", 32'(busy84), 0);
        check("rst_busy42", 32'(busy42), 0);
        rst = 1'b0;
        tick;

        vecs.push_back('{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8});
        vecs.push_back('{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8});
        vecs.push_back('{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8});
        vecs.push_back('{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8});
        vecs.push_back('{1, 8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0, 2});
        vecs.push_back('{1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 2});
        vecs.push_back('{2, 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b1, 2});
        vecs.push_back('{2, 8'h0F, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8});
        vecs.push_back('{0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 8});

        foreach (vecs[i]) begin
            do_op(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            tick;
            check($sformatf("vec%0d_pulse", i), 32'(dn(vecs[i].dut)), 0);
        end

        // Reset mid-run: no done, outputs cleared (sum81 currently 0xFF).
        a81 = 8'h12; b81 = 8'h34; c81 = 0; s81 = 1;
        tick;
        s81 = 0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_busy", 32'(busy81), 0);
        check("abort_done", 32'(done81), 0);
        check("abort_sum", 32'(sum81), 0);
        seen = 1'b0;
        repeat (12) begin
            tick;
            if (done81) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 0);
        do_op(0, 8'h12, 8'h34, 1'b0, s, co, ov, lat);
        check("after_abort_sum", 32'(s), 32'h46);
        tick;

        // Start during busy is ignored.
        a81 = 8'h0F; b81 = 8'h01; c81 = 0; s81 = 1;
        tick;
        s81 = 0;
        repeat (3) tick;
        a81 = 8'hFF; s81 = 1;
        tick;
        s81 = 0;
        check("ignored_busy", 32'(busy81), 1);
        n = 4;
        while (!done81 && n < 40) begin
            tick;
            n++;
        end
        check("ignored_lat", 32'(n), 8);
        check("ignored_sum", 32'(sum81), 32'h10);
        check("ignored_busy_at_done", 32'(busy81), 0);

        // Restart in the done cycle.
        a81 = 8'h80; b81 = 8'h80; c81 = 0; s81 = 1;
        tick;
        s81 = 0;
        check("b2b_done_low", 32'(done81), 0);
        check("b2b_busy", 32'(busy81), 1);
        check("b2b_hold_sum", 32'(sum81), 32'h10);
        n = 1;
        while (!done81 && n < 40) begin
            tick;
            n++;
        end
        check("b2b_spacing", 32'(n), 9);
        check("b2b_sum", 32'(sum81), 0);
        check("b2b_cout", 32'(cout81), 1);
        check("b2b_ovf", 32'(ovf81), 1);
        tick;

        // Random operands on both 8-bit configurations.
        for (int i = 0; i < 60; i++) begin
            int w;
            w  = i % 2;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            ref_add(8, int'(ra), int'(rb), int'(rc), es, eco, eov);
            do_op(w, ra, rb, rc, s, co, ov, lat);
            check($sformatf("rnd%0d_sum a=%0h b=%0h c=%0b", i, ra, rb, rc), 32'(s), 32'(es));
            check($sformatf("rnd%0d_cout", i), 32'(co), 32'(eco));
            check($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
        end

        // Exhaustive sweep of the 4-bit, 2-digit configuration.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    ref_add(4, av, bv, cv, es, eco, eov);
                    do_op(2, 8'(av), 8'(bv), 1'(cv), s, co, ov, lat);
                    check($sformatf("sw_sum a=%0d b=%0d c=%0d", av, bv, cv), 32'(s), 32'(es));
                    check($sformatf("sw_cout a=%0d b=%0d c=%0d", av, bv, cv), 32'(co), 32'(eco));
                    check($sformatf("sw_ovf a=%0d b=%0d c=%0d", av, bv, cv), 32'(ov), 32'(eov));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
